argon_alu_seq: RTL
==================

Name: argon_alu_seq

Overview:
- Parametrised successor to the Argon single-bus ALU.
- Keeps the A/B/F/Op/Y register model and the latch/compute/output command flow.
- Generalises data width and adds a registered result path, a busy/done handshake, and an optional multi-cycle shift-add multiplier with a high result half.
- Sits on the CPU data bus as a command-driven peripheral.

Parameters:
- WIDTH, 16, data word width; power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- i_Clk  in  1  system clock; all state on rising edge.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_command  in  4  bus command code.
- i_valid  in  1  command qualifier; the command is ignored when low.
- i_data  in  WIDTH  bus write data.
- o_data  out  WIDTH  bus read data (combinational from registers).
- o_valid  out  1  o_data valid.
- o_busy  out  1  multi-cycle operation in progress.
- o_done  out  1  one-cycle pulse after a result/flag write.

Behaviour:
- Command codes: 1 LATCHA, 2 LATCHB, 3 LATCHF (loads i_data[7:0]), 4 LATCHOP (loads i_data[3:0]), 5 COMPUTE, 6 OUTPUTY, 7 OUTPUTF, 8 OUTPUTYH. All other codes: no-op.
- Opcodes:
  - 0 ADD, 1 ADC, 2 SBC, 3 CMP, 4 INC, 5 DEC, 6 NAND, 7 AND.
  - 8 OR, 9 NOR, 10 XOR, 11 LSH, 12 RSH, 13 ROL, 14 ROR, 15 MUL.
- Flag bits in the 8-bit rF: 0 CARRY, 1 ZERO, 2 EQUAL, 3 GREATER, 4 LESS, 5 ERROR; bits 7:6 always written 0 by COMPUTE.
- Reset: rA, rB, rY, rYH, rF, rOp = 0; state IDLE; o_busy = 0; o_done = 0; o_valid = 0; o_data = 0.
- States:
  - IDLE: accepts every command.
  - MUL: one iteration per cycle, for WIDTH cycles.
- Single-cycle opcodes (0–14), COMPUTE accepted at edge N:
  - rY and rF written at edge N.
  - o_done is high in the cycle after edge N.
  - rYH is cleared to 0.
- Arithmetic is performed at WIDTH+1 bits; CARRY is bit WIDTH of the result.
  - ADD, ADC: CARRY = carry out; ADC adds rF.CARRY.
  - SBC: Y = A − B − (1 − rF.CARRY); CARRY = 1 iff no borrow.
- CMP:
  - rY is unchanged.
  - EQUAL, GREATER, LESS compare A with B, unsigned.
  - ZERO = EQUAL.
- INC/DEC wrap modulo 2^WIDTH.
  - INC: CARRY = 1 on the 0xFF..F→0 wrap.
  - DEC: CARRY = 1 on the 0→0xFF..F wrap.
- Logic ops: CARRY = 0.
- Shifts and rotates use amount B[SHW-1:0].
  - Rotate by 0 returns A.
  - LSH: CARRY = last bit shifted out (0 if amount is 0).
- ZERO = (Y == 0) for every opcode except CMP.
- MUL (ALU_MUL_EN defined):
  - COMPUTE accepted at edge N enters MUL; o_busy is high from after edge N until edge N+WIDTH.
  - Unsigned shift-add runs one multiplier bit per cycle, using internal copies of A and B.
  - At edge N+WIDTH: {rYH, rY} = A×B (2·WIDTH bits); CARRY = (rYH != 0); ZERO = (product == 0); return to IDLE.
  - o_done pulses in the cycle after edge N+WIDTH.
- While o_busy = 1:
  - LATCH* and COMPUTE are dropped; no register changes.
  - OUTPUT* commands return o_valid = 0 and o_data = 0.
- Outputs when not busy:
  - OUTPUTY: o_data = rY.
  - OUTPUTF: o_data = {0, rF}.
  - OUTPUTYH: o_data = rYH.
  - Each of these sets o_valid = 1, combinationally in the same cycle as i_command/i_valid.
- Non-output commands, or i_valid = 0: o_data = 0, o_valid = 0.
- Reset asserted mid-MUL: aborts immediately; all registers return to reset values; no o_done.
- LATCHF followed by COMPUTE: COMPUTE overwrites rF (the carry-in is read before the write).

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL opcode is implemented as above; the MUL state exists.
- Undefined:
  - MUL is a single-cycle error: rY = 0, rYH = 0, rF = only ERROR set; o_busy is never asserted.
  - OUTPUTYH returns 0 with o_valid = 1.
  - No multiplier logic is synthesised.

Test Plan (WIDTH=16):
- Reset, then OUTPUTY/OUTPUTF/OUTPUTYH → each o_data = 0x0000, o_valid = 1; o_busy = 0.
- A=0xFFFF, B=0x0001, ADD → Y = 0x0000, F = 0x03 (CARRY, ZERO); then ADC with A=1, B=1 → Y = 0x0003, F = 0x00.
- A=0x0005, B=0x0009, CMP after Y=0x1234 → Y still 0x1234, F = 0x10 (LESS); then A=9 → F = 0x06 (ZERO, EQUAL).
- A=0x8001, B=0x0011, ROL → Y = 0x0003 (amount 1); B=0x0010 → Y = 0x8001.
- ALU_MUL_EN defined: A=0x1234, B=0x0100, MUL:
  - o_busy high for 16 cycles; LATCHA 0xAAAA during busy is ignored.
  - Then Y = 0x3400, YH = 0x0012, F = 0x01, one o_done pulse.
- MUL in flight, i_Reset_n low at cycle 7 → o_busy = 0 immediately; Y, YH, F = 0; no o_done. ALU_MUL_EN undefined: MUL → F = 0x20, o_busy never high.

Source files
------------

// File: rtl/argon_alu_seq.sv
// argon_alu_seq: command-driven bus ALU with registered A/B/F/Op/Y/YH state,
// a busy/done handshake and an optional multi-cycle shift-add multiplier.
// Optional feature macro: ALU_MUL_EN (defined = sequential MUL opcode and
// high result half; undefined = MUL is a single-cycle ERROR result).
module argon_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic [3:0]       i_command,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [3:0] CMD_LATCHA   = 4'd1;
    localparam logic [3:0] CMD_LATCHB   = 4'd2;
    localparam logic [3:0] CMD_LATCHF   = 4'd3;
    localparam logic [3:0] CMD_LATCHOP  = 4'd4;
    localparam logic [3:0] CMD_COMPUTE  = 4'd5;
    localparam logic [3:0] CMD_OUTPUTY  = 4'd6;
    localparam logic [3:0] CMD_OUTPUTF  = 4'd7;
    localparam logic [3:0] CMD_OUTPUTYH = 4'd8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SBC  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_INC  = 4'd4;
    localparam logic [3:0] OP_DEC  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_LSH  = 4'd11;
    localparam logic [3:0] OP_RSH  = 4'd12;
    localparam logic [3:0] OP_ROL  = 4'd13;
    localparam logic [3:0] OP_ROR  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, yh_q, yh_d;
    logic [7:0]       f_q, f_d;
    logic [3:0]       op_q, op_d;
    logic             done_q, done_d;
    logic             busy;

    logic [WIDTH-1:0]   alu_y;
    logic [7:0]         alu_f;
    logic [WIDTH:0]     wide;
    logic [2*WIDTH-1:0] rot;
    logic [SHW-1:0]     amt;
    logic               carry, eq, gt, lt, zero;

`ifdef ALU_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    assign busy = (state_q == S_MUL);
`else
    assign busy = 1'b0;
`endif

    assign o_busy = busy;
    assign o_done = done_q;

    // Single-cycle datapath: result word and flag byte for opcodes 0-14
    always_comb begin
        alu_y = y_q;
        carry = 1'b0;
        eq    = 1'b0;
        gt    = 1'b0;
        lt    = 1'b0;
        wide  = '0;
        rot   = '0;
        amt   = b_q[SHW-1:0];
        case (op_q)
            OP_ADD: begin
                wide  = {1'b0, a_q} + {1'b0, b_q};
                alu_y = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_ADC: begin
                wide  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, f_q[0]};
                alu_y = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_SBC: begin
                wide  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, ~f_q[0]};
                alu_y = wide[WIDTH-1:0];
                carry = ~wide[WIDTH];
            end
            OP_CMP: begin
                eq = (a_q == b_q);
                gt = (a_q > b_q);
                lt = (a_q < b_q);
            end
            OP_INC: begin
                alu_y = a_q + 1'b1;
                carry = (a_q == {WIDTH{1'b1}});
            end
            OP_DEC: begin
                alu_y = a_q - 1'b1;
                carry = (a_q == '0);
            end
            OP_NAND: alu_y = ~(a_q & b_q);
            OP_AND:  alu_y = a_q & b_q;
            OP_OR:   alu_y = a_q | b_q;
            OP_NOR:  alu_y = ~(a_q | b_q);
            OP_XOR:  alu_y = a_q ^ b_q;
            OP_LSH: begin
                wide  = {1'b0, a_q} << amt;
                alu_y = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_RSH: alu_y = a_q >> amt;
            OP_ROL: begin
                rot   = {a_q, a_q} << amt;
                alu_y = rot[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                rot   = {a_q, a_q} >> amt;
                alu_y = rot[WIDTH-1:0];
            end
            OP_MUL:  alu_y = '0;
            default: alu_y = y_q;
        endcase
        zero  = (op_q == OP_CMP) ? eq : (alu_y == '0);
        alu_f = {2'b00, 1'b0, lt, gt, eq, zero, carry};
    end

    // Command decode and next-state for all architectural and multiplier state
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        y_d    = y_q;
        yh_d   = yh_q;
        f_d    = f_q;
        op_d   = op_q;
        done_d = 1'b0;
`ifdef ALU_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        step     = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        if (i_valid && !busy) begin
            case (i_command)
                CMD_LATCHA:  a_d  = i_data;
                CMD_LATCHB:  b_d  = i_data;
                CMD_LATCHF:  f_d  = i_data[7:0];
                CMD_LATCHOP: op_d = i_data[3:0];
                CMD_COMPUTE: begin
                    if (op_q == OP_MUL) begin
`ifdef ALU_MUL_EN
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, a_q};
                        mplier_d = b_q;
                        acc_d    = '0;
                        cnt_d    = '0;
`else
                        y_d    = '0;
                        yh_d   = '0;
                        f_d    = 8'h20;
                        done_d = 1'b1;
`endif
                    end else begin
                        y_d    = alu_y;
                        yh_d   = '0;
                        f_d    = alu_f;
                        done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef ALU_MUL_EN
        if (state_q == S_MUL) begin
            acc_d    = step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 1)) begin
                y_d     = step[WIDTH-1:0];
                yh_d    = step[2*WIDTH-1:WIDTH];
                f_d     = {6'b000000, (step == '0), (step[2*WIDTH-1:WIDTH] != '0)};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
`endif
    end

    // State registers; reset aborts any multiply in progress
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            yh_q     <= '0;
            f_q      <= '0;
            op_q     <= '0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
            yh_q     <= yh_d;
            f_q      <= f_d;
            op_q     <= op_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Bus read port: combinational from registers, silent while busy or in reset
    always_comb begin
        o_data  = '0;
        o_valid = 1'b0;
        if (i_Reset_n && i_valid && !busy) begin
            case (i_command)
                CMD_OUTPUTY: begin
                    o_data  = y_q;
                    o_valid = 1'b1;
                end
                CMD_OUTPUTF: begin
                    o_data[7:0] = f_q;
                    o_valid     = 1'b1;
                end
                CMD_OUTPUTYH: begin
                    o_data  = yh_q;
                    o_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
